// File: rtl/cellrv32_sysinfo_ext.sv
// System-information unit: read-only config words, 64-bit uptime counter with hi/lo shadow,
// scratch register and write-once lock, behind a fixed-latency response pipeline.
module cellrv32_sysinfo_ext #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFFFFC0,
  parameter int          ADDR_WIDTH      = 6,
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd0,
  parameter logic [31:0] CUSTOM_ID       = 32'h0,
  parameter logic [31:0] FEATURES        = 32'h0,
  parameter logic [31:0] CACHE_CFG       = 32'h0,
  parameter int          NUM_USER_WORDS  = 0,
  parameter int          READ_LATENCY    = 1
) (
  input  logic                                                clk_i,
  input  logic                                                rstn_i,
  input  logic [31:0]                                         addr_i,
  input  logic                                                rden_i,
  input  logic                                                wren_i,
  input  logic [31:0]                                         data_i,
  input  logic [32*((NUM_USER_WORDS > 0) ? NUM_USER_WORDS : 1)-1:0] user_info_i,
  output logic [31:0]                                         data_o,
  output logic                                                ack_o,
  output logic                                                err_o,
  output logic                                                lock_o
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int NW = 8 + NUM_USER_WORDS;

  logic [63:0] r_cnt;
  logic [31:0] r_shadow;
  logic [31:0] r_scratch;
  logic        r_lock;
  logic        r_halt;
  logic        r_ack_p  [READ_LATENCY];
  logic        r_err_p  [READ_LATENCY];
  logic [31:0] r_data_p [READ_LATENCY];

  logic          w_acc;
  logic [IW-1:0] w_idx;
  logic          w_in_range;
  logic          w_rw_idx;
  logic          w_err;
  logic          w_ok_rd;
  logic          w_ok_wr;
  logic          w_clr;
  logic [31:0]   w_rdata;

  assign w_acc      = (addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign w_idx      = addr_i[ADDR_WIDTH-1:2];
  assign w_in_range = (32'(w_idx) < 32'(NW));
  assign w_rw_idx   = (w_idx == IW'(6)) || (w_idx == IW'(7));

  // Only SCRATCH and CTRL are writable, and only while unlocked.
  assign w_err   = w_acc & ((rden_i & wren_i) | (~w_in_range & (rden_i | wren_i)) |
                            (wren_i & ~w_rw_idx) | (wren_i & r_lock));
  assign w_ok_rd = w_acc & rden_i & ~w_err;
  assign w_ok_wr = w_acc & wren_i & ~w_err;
  assign w_clr   = w_ok_wr & (w_idx == IW'(7)) & data_i[1];

  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      IW'(0):  w_rdata = CLOCK_FREQUENCY;
      IW'(1):  w_rdata = CUSTOM_ID;
      IW'(2):  w_rdata = FEATURES;
      IW'(3):  w_rdata = CACHE_CFG;
      IW'(4):  w_rdata = r_cnt[31:0];
      IW'(5):  w_rdata = r_shadow;
      IW'(6):  w_rdata = r_scratch;
      IW'(7):  w_rdata = {29'h0, r_halt, 1'b0, r_lock};
      default: w_rdata = 32'h0;
    endcase
    for (int k = 0; k < NUM_USER_WORDS; k++) begin
      if (32'(w_idx) == 32'(8 + k)) w_rdata = user_info_i[32*k +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cnt     <= 64'h0;
      r_shadow  <= 32'h0;
      r_scratch <= 32'h0;
      r_lock    <= 1'b0;
      r_halt    <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_ack_p[i]  <= 1'b0;
        r_err_p[i]  <= 1'b0;
        r_data_p[i] <= 32'h0;
      end
    end else begin
      if (w_clr)        r_cnt <= 64'h0;
      else if (!r_halt) r_cnt <= r_cnt + 64'd1;

      // Shadow latches the upper half together with the lower-half read.
      if (w_ok_rd && (w_idx == IW'(4))) r_shadow <= r_cnt[63:32];
      if (w_ok_wr && (w_idx == IW'(6))) r_scratch <= data_i;
      if (w_ok_wr && (w_idx == IW'(7))) begin
        r_lock <= r_lock | data_i[0];
        r_halt <= data_i[2];
      end

      r_ack_p[0]  <= w_ok_rd | w_ok_wr;
      r_err_p[0]  <= w_err;
      r_data_p[0] <= w_ok_rd ? w_rdata : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_ack_p[i]  <= r_ack_p[i-1];
        r_err_p[i]  <= r_err_p[i-1];
        r_data_p[i] <= r_data_p[i-1];
      end
    end
  end

  assign ack_o  = r_ack_p[READ_LATENCY-1];
  assign err_o  = r_err_p[READ_LATENCY-1];
  assign data_o = r_data_p[READ_LATENCY-1];
  assign lock_o = r_lock;

endmodule

// File: tb/tb_cellrv32_sysinfo_ext.sv
// Bench for cellrv32_sysinfo_ext: cycle-level reference model for a latency-2 instance,
// plus directed checks on a latency-3 instance without user words.
module tb_cellrv32_sysinfo_ext;

  localparam int          L    = 2;
  localparam int          NU   = 2;
  localparam logic [31:0] BASE = 32'hFFFFFFC0;
  localparam logic [31:0] CLKF = 32'd100000000;
  localparam logic [31:0] CID  = 32'h12345678;
  localparam logic [31:0] FEAT = 32'h000000A5;
  localparam logic [31:0] CCFG = 32'h00402010;
  localparam logic [63:0] USER = 64'h11112222_33334444;

  logic        clk_i = 1'b0;
  logic        rstn;
  logic [31:0] b_addr, b_din;
  logic        b_rd, b_wr;
  logic [31:0] d_out;
  logic        d_ack, d_err, d_lock;

  logic        rstn3;
  logic [31:0] a3;
  logic        rd3, wr3;
  logic [31:0] d3_out;
  logic        d3_ack, d3_err, d3_lock;

  always #5 clk_i = ~clk_i;

  cellrv32_sysinfo_ext #(
    .BASE_ADDR(BASE), .ADDR_WIDTH(6), .CLOCK_FREQUENCY(CLKF), .CUSTOM_ID(CID),
    .FEATURES(FEAT), .CACHE_CFG(CCFG), .NUM_USER_WORDS(NU), .READ_LATENCY(L)
  ) u_dut (
    .clk_i(clk_i), .rstn_i(rstn), .addr_i(b_addr), .rden_i(b_rd), .wren_i(b_wr),
    .data_i(b_din), .user_info_i(USER), .data_o(d_out), .ack_o(d_ack), .err_o(d_err),
    .lock_o(d_lock)
  );

  cellrv32_sysinfo_ext #(
    .BASE_ADDR(BASE), .ADDR_WIDTH(6), .CLOCK_FREQUENCY(32'd1234), .CUSTOM_ID(32'hC0FFEE01),
    .FEATURES(32'h000000F3), .CACHE_CFG(32'h0), .NUM_USER_WORDS(0), .READ_LATENCY(3)
  ) u_dut3 (
    .clk_i(clk_i), .rstn_i(rstn3), .addr_i(a3), .rden_i(rd3), .wren_i(wr3),
    .data_i(32'h0), .user_info_i(32'hFFFF_FFFF), .data_o(d3_out), .ack_o(d3_ack),
    .err_o(d3_err), .lock_o(d3_lock)
  );

  // Reference model: architectural state plus expected response per future cycle.
  int          cyc = 0;
  logic [63:0] m_cnt;
  logic [31:0] m_shadow, m_scratch;
  bit          m_lock, m_halt;
  bit          s_ack [8];
  bit          s_err [8];
  logic [31:0] s_dat [8];
  int          m_idx, m_slot;
  bit          m_acc, m_e, m_clr, m_nh;

  function automatic logic [31:0] word(input int idx);
    case (idx)
      0: return CLKF;
      1: return CID;
      2: return FEAT;
      3: return CCFG;
      4: return m_cnt[31:0];
      5: return m_shadow;
      6: return m_scratch;
      7: return {29'h0, m_halt, 1'b0, m_lock};
      8: return USER[31:0];
      9: return USER[63:32];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (!rstn) begin
      m_cnt = 64'h0; m_shadow = 32'h0; m_scratch = 32'h0; m_lock = 1'b0; m_halt = 1'b0;
      for (int i = 0; i < 8; i++) begin s_ack[i] = 1'b0; s_err[i] = 1'b0; s_dat[i] = 32'h0; end
    end else begin
      s_ack[(cyc-1)%8] = 1'b0; s_err[(cyc-1)%8] = 1'b0; s_dat[(cyc-1)%8] = 32'h0;
      m_slot = (cyc - 1 + L) % 8;
      m_acc  = (b_addr[31:6] == BASE[31:6]);
      m_idx  = int'(b_addr[5:2]);
      m_clr  = 1'b0;
      m_nh   = m_halt;
      if (m_acc && (b_rd || b_wr)) begin
        m_e = (b_rd && b_wr) || (m_idx >= 8 + NU) || (b_wr && (m_idx < 6 || m_idx >= 8)) ||
              (b_wr && m_lock);
        if (m_e) s_err[m_slot] = 1'b1;
        else begin
          s_ack[m_slot] = 1'b1;
          if (b_rd) begin
            s_dat[m_slot] = word(m_idx);
            if (m_idx == 4) m_shadow = m_cnt[63:32];
          end else if (m_idx == 6) m_scratch = b_din;
          else begin
            m_lock = m_lock | b_din[0];
            m_nh   = b_din[2];
            m_clr  = b_din[1];
          end
        end
      end
      if (m_clr)        m_cnt = 64'h0;
      else if (!m_halt) m_cnt = m_cnt + 64'd1;
      m_halt = m_nh;
    end
  end

  int          nchk = 0;
  int          npass = 0;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // One bus cycle: check the outputs of the cycle that is ending, then drive the next request.
  task automatic step(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] din);
    @(negedge clk_i);
    chk("ack", 64'(d_ack), 64'(s_ack[cyc%8]));
    chk("err", 64'(d_err), 64'(s_err[cyc%8]));
    chk("data", 64'(d_out), 64'(s_dat[cyc%8]));
    chk("lock", 64'(d_lock), 64'(m_lock));
    if (d_ack) last_data = d_out;
    b_rd = rd; b_wr = wr; b_addr = addr; b_din = din;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] wa(input int idx);
    return BASE | 32'(idx * 4);
  endfunction

  logic [31:0] v_a, v_b, v_addr, v_din;
  int          v_sel, v_idx;

  initial begin
    rstn = 1'b0; rstn3 = 1'b0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_din = 32'h0;
    rd3 = 1'b0; wr3 = 1'b0; a3 = 32'h0;
    last_data = 32'h0;
    idle(3);
    rstn = 1'b1; rstn3 = 1'b1;
    idle(2);

    // Clock-frequency word, latency 2, zero data outside the ack cycle.
    step(1'b1, 1'b0, wa(0), 32'h0);
    idle(L + 1);
    chk("clkfreq", 64'(last_data), 64'h05F5E100);

    // Upper half comes from the shadow captured by the preceding LO read.
    step(1'b1, 1'b0, wa(4), 32'h0);
    idle(3);
    step(1'b1, 1'b0, wa(5), 32'h0);
    idle(L + 1);
    chk("uptime_hi", 64'(last_data), 64'(m_shadow));

    // Halt freezes the counter; clr restarts it from zero.
    step(1'b0, 1'b1, wa(7), 32'h4);
    step(1'b1, 1'b0, wa(4), 32'h0);
    idle(L + 1);
    v_a = last_data;
    idle(100);
    step(1'b1, 1'b0, wa(4), 32'h0);
    idle(L + 1);
    chk("halt_frozen", 64'(last_data), 64'(v_a));
    step(1'b0, 1'b1, wa(7), 32'h2);
    step(1'b1, 1'b0, wa(4), 32'h0);
    idle(L + 1);
    chk("clr_small", 64'(last_data < 32'd4), 64'h1);

    // Randomized traffic, back-to-back, no lock.
    for (int n = 0; n < 200; n++) begin
      v_sel = int'($urandom_range(0, 9));
      v_idx = int'($urandom_range(0, 15));
      v_addr = ($urandom_range(0, 9) == 0) ? $urandom : (wa(v_idx) | 32'($urandom_range(0, 3)));
      v_din = $urandom;
      if (v_idx == 7) v_din = v_din & 32'hFFFF_FFFE;
      if (v_sel <= 4)      step(1'b1, 1'b0, v_addr, v_din);
      else if (v_sel <= 7) step(1'b0, 1'b1, v_addr, v_din);
      else if (v_sel == 8) step(1'b1, 1'b1, v_addr, v_din);
      else                 step(1'b0, 1'b0, v_addr, v_din);
    end
    idle(4);

    // Error paths leave state untouched.
    step(1'b0, 1'b1, wa(6), 32'h0BADF00D);
    step(1'b1, 1'b1, wa(6), 32'h11111111);
    step(1'b1, 1'b0, wa(10), 32'h0);
    step(1'b0, 1'b1, wa(0), 32'h22222222);
    step(1'b0, 1'b1, wa(8), 32'h33333333);
    step(1'b1, 1'b0, wa(6), 32'h0);
    idle(L + 1);
    chk("scratch_kept", 64'(last_data), 64'h0BADF00D);

    // Scratch, then lock, then locked writes rejected.
    step(1'b0, 1'b1, wa(6), 32'hDEADBEEF);
    step(1'b1, 1'b0, wa(6), 32'h0);
    idle(L + 1);
    chk("scratch_rd", 64'(last_data), 64'hDEADBEEF);
    step(1'b0, 1'b1, wa(7), 32'h1);
    idle(2);
    chk("lock_set", 64'(d_lock), 64'h1);
    step(1'b0, 1'b1, wa(6), 32'h0);
    step(1'b0, 1'b1, wa(7), 32'h0);
    step(1'b1, 1'b0, wa(6), 32'h0);
    idle(L + 1);
    chk("scratch_locked", 64'(last_data), 64'hDEADBEEF);
    chk("lock_held", 64'(d_lock), 64'h1);

    // Latency-3 instance: three reads back to back give three ordered acks.
    for (int c = 0; c < 8; c++) begin
      idle(1);
      chk("l3_ack", 64'(d3_ack), 64'(c >= 3 && c <= 5));
      chk("l3_data", 64'(d3_out),
          (c == 3) ? 64'd1234 : (c == 4) ? 64'hC0FFEE01 : (c == 5) ? 64'hF3 : 64'h0);
      rd3 = (c < 3);
      a3  = wa(c);
    end
    // Out-of-range read with no user words.
    for (int c = 0; c < 6; c++) begin
      idle(1);
      chk("l3_err", 64'(d3_err), 64'(c == 3));
      chk("l3_noack", 64'(d3_ack), 64'h0);
      rd3 = (c == 0);
      a3  = wa(8);
    end
    // Reset after the second request discards both responses.
    for (int c = 0; c < 8; c++) begin
      idle(1);
      chk("l3_rst", 64'({d3_ack, d3_err}), 64'h0);
      rd3   = (c < 2);
      a3    = wa(c);
      rstn3 = !(c == 2 || c == 3);
    end
    rstn3 = 1'b1;

    // Reset clears lock and scratch.
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    chk("rst_lock", 64'(d_lock), 64'h0);
    step(1'b1, 1'b0, wa(6), 32'h0);
    idle(L + 1);
    chk("rst_scratch", 64'(last_data), 64'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
